// File: rtl/pkt_ident_stream_if.sv
// Beat-level bus of the framing-token classifier: the input beat with its
// per-byte valid and downstream hold, plus the registered classified beat.
// With PKT_CNT_EN defined the bus also carries the TLP/DLLP packet counters.
interface pkt_ident_stream_if #(
    parameter int NBYTES = 64
) ();
    logic [8*NBYTES-1:0] Data_in;
    logic [NBYTES-1:0]   valid;
    logic                hld_pd;
    logic [8*NBYTES-1:0] Data_out;
    logic [3*NBYTES-1:0] ByteType;
    logic                w;
    logic                err;
`ifdef PKT_CNT_EN
    logic [15:0]         tlp_cnt;
    logic [15:0]         dllp_cnt;
`endif

`ifdef PKT_CNT_EN
    modport master (
        output Data_in, valid, hld_pd,
        input  Data_out, ByteType, w, err, tlp_cnt, dllp_cnt
    );
    modport slave (
        input  Data_in, valid, hld_pd,
        output Data_out, ByteType, w, err, tlp_cnt, dllp_cnt
    );
`else
    modport master (
        output Data_in, valid, hld_pd,
        input  Data_out, ByteType, w, err
    );
    modport slave (
        input  Data_in, valid, hld_pd,
        output Data_out, ByteType, w, err
    );
`endif
endinterface

// File: rtl/pkt_ident_stream.sv
// Stateful framing-token classifier: tags every valid byte of a beat and carries
// packet context across beats. Optional PKT_CNT_EN adds TLP/DLLP packet counters.
//
// state       | meaning
// ------------+---------------------------------------------------------
// CTX_OUTSIDE | between packets; STP/SDP open a packet, END is an error
// CTX_IN_TLP  | inside a TLP; END closes it, STP/SDP abort it
// CTX_IN_DLLP | inside a DLLP; END closes it, STP/SDP abort it
module pkt_ident_stream #(
    parameter int         NBYTES  = 64,
    parameter logic [7:0] STP_TOK = 8'hFB,
    parameter logic [7:0] SDP_TOK = 8'h5C,
    parameter logic [7:0] END_TOK = 8'hFD
) (
    input logic              clk,
    input logic              rst,
    pkt_ident_stream_if.slave bus
);

    localparam logic [2:0] TYPE_INVALID = 3'b000;
    localparam logic [2:0] TYPE_IDLE    = 3'b001;
    localparam logic [2:0] TYPE_STP     = 3'b010;
    localparam logic [2:0] TYPE_SDP     = 3'b011;
    localparam logic [2:0] TYPE_END     = 3'b100;
    localparam logic [2:0] TYPE_TLP     = 3'b101;
    localparam logic [2:0] TYPE_DLLP    = 3'b110;
    localparam logic [2:0] TYPE_ERR     = 3'b111;

    typedef enum logic [1:0] {
        CTX_OUTSIDE = 2'd0,
        CTX_IN_TLP  = 2'd1,
        CTX_IN_DLLP = 2'd2
    } ctx_t;

    ctx_t                ctx_q;
    ctx_t                ctx_nxt;
    logic [3*NBYTES-1:0] type_nxt;
    logic                err_nxt;
    logic                any_valid;

    logic [8*NBYTES-1:0] data_q;
    logic [3*NBYTES-1:0] type_q;
    logic                w_q;
    logic                err_q;

`ifdef PKT_CNT_EN
    logic [15:0]         tlp_ends;
    logic [15:0]         dllp_ends;
    logic [15:0]         tlp_cnt_q;
    logic [15:0]         dllp_cnt_q;
`endif

    // Byte-serial context walk: each valid byte sees the context left by the
    // byte before it, so the last byte's context is what gets registered.
    always_comb begin
        ctx_nxt   = ctx_q;
        type_nxt  = '0;
        err_nxt   = 1'b0;
        any_valid = |bus.valid;
`ifdef PKT_CNT_EN
        tlp_ends  = '0;
        dllp_ends = '0;
`endif
        for (int i = 0; i < NBYTES; i++) begin
            if (bus.valid[i]) begin
                unique case (ctx_nxt)
                    CTX_OUTSIDE: begin
                        if (bus.Data_in[8*i +: 8] == STP_TOK) begin
                            type_nxt[3*i +: 3] = TYPE_STP;
                            ctx_nxt            = CTX_IN_TLP;
                        end else if (bus.Data_in[8*i +: 8] == SDP_TOK) begin
                            type_nxt[3*i +: 3] = TYPE_SDP;
                            ctx_nxt            = CTX_IN_DLLP;
                        end else if (bus.Data_in[8*i +: 8] == END_TOK) begin
                            type_nxt[3*i +: 3] = TYPE_ERR;
                        end else begin
                            type_nxt[3*i +: 3] = TYPE_IDLE;
                        end
                    end
                    CTX_IN_TLP, CTX_IN_DLLP: begin
                        if (bus.Data_in[8*i +: 8] == END_TOK) begin
                            type_nxt[3*i +: 3] = TYPE_END;
`ifdef PKT_CNT_EN
                            if (ctx_nxt == CTX_IN_TLP) tlp_ends = tlp_ends + 16'd1;
                            else                       dllp_ends = dllp_ends + 16'd1;
`endif
                            ctx_nxt            = CTX_OUTSIDE;
                        end else if (bus.Data_in[8*i +: 8] == STP_TOK ||
                                     bus.Data_in[8*i +: 8] == SDP_TOK) begin
                            // A new start token inside a packet aborts it.
                            type_nxt[3*i +: 3] = TYPE_ERR;
                            ctx_nxt            = CTX_OUTSIDE;
                        end else if (ctx_nxt == CTX_IN_TLP) begin
                            type_nxt[3*i +: 3] = TYPE_TLP;
                        end else begin
                            type_nxt[3*i +: 3] = TYPE_DLLP;
                        end
                    end
                    default: begin
                        type_nxt[3*i +: 3] = TYPE_ERR;
                        ctx_nxt            = CTX_OUTSIDE;
                    end
                endcase
            end else begin
                type_nxt[3*i +: 3] = TYPE_INVALID;
            end
            if (type_nxt[3*i +: 3] == TYPE_ERR) err_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctx_q      <= CTX_OUTSIDE;
            data_q     <= '0;
            type_q     <= '0;
            w_q        <= 1'b0;
            err_q      <= 1'b0;
`ifdef PKT_CNT_EN
            tlp_cnt_q  <= '0;
            dllp_cnt_q <= '0;
`endif
        end else if (!bus.hld_pd) begin
            ctx_q      <= ctx_nxt;
            data_q     <= bus.Data_in;
            type_q     <= type_nxt;
            w_q        <= any_valid;
            err_q      <= err_nxt;
`ifdef PKT_CNT_EN
            tlp_cnt_q  <= tlp_cnt_q + tlp_ends;
            dllp_cnt_q <= dllp_cnt_q + dllp_ends;
`endif
        end else begin
            w_q        <= 1'b0;
            err_q      <= 1'b0;
        end
    end

    assign bus.Data_out = data_q;
    assign bus.ByteType = type_q;
    assign bus.w        = w_q;
    assign bus.err      = err_q;
`ifdef PKT_CNT_EN
    assign bus.tlp_cnt  = tlp_cnt_q;
    assign bus.dllp_cnt = dllp_cnt_q;
`endif

endmodule

// File: tb/tb_pkt_ident_stream.sv
// Directed bench for pkt_ident_stream at NBYTES=8; counter checks are active
// when PKT_CNT_EN is defined.
module tb_pkt_ident_stream;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    pkt_ident_stream_if #(.NBYTES(8)) bus ();

    pkt_ident_stream #(.NBYTES(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a beat, let one rising edge take it, then sample 1ns later.
    task automatic step(input logic [63:0] d, input logic [7:0] v, input logic h);
        bus.Data_in = d;
        bus.valid   = v;
        bus.hld_pd  = h;
        @(posedge clk);
        #1;
    endtask

    task automatic check_beat(input string tag, input logic [63:0] d, input logic [23:0] t,
                              input logic w_exp, input logic err_exp);
        check({tag, ".data"}, bus.Data_out, d);
        check({tag, ".type"}, {40'd0, bus.ByteType}, {40'd0, t});
        check({tag, ".w"},    {63'd0, bus.w},   {63'd0, w_exp});
        check({tag, ".err"},  {63'd0, bus.err}, {63'd0, err_exp});
    endtask

    task automatic check_cnt(input string tag, input logic [15:0] tlp, input logic [15:0] dllp);
`ifdef PKT_CNT_EN
        check({tag, ".tlp_cnt"},  {48'd0, bus.tlp_cnt},  {48'd0, tlp});
        check({tag, ".dllp_cnt"}, {48'd0, bus.dllp_cnt}, {48'd0, dllp});
`else
        if (tlp == 16'hFFFF && dllp == 16'hFFFF) $display("counters not built (%s)", tag);
`endif
    endtask

    initial begin
        bus.Data_in = '0;
        bus.valid   = '0;
        bus.hld_pd  = 1'b0;

        #2 rst = 1'b1;
        #1;
        check_beat("reset", 64'h0, 24'o0, 1'b0, 1'b0);
        check_cnt("reset", 16'd0, 16'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // Mixed beat: packet closes at byte 3, stray END at byte 6.
        step(64'h12FD3412FD5634FB, 8'hFF, 1'b0);
        check_beat("mixed", 64'h12FD3412FD5634FB, 24'o17114552, 1'b1, 1'b1);
        check_cnt("mixed", 16'd1, 16'd0);

        // TLP spanning three beats.
        step(64'h07060504030201FB, 8'hFF, 1'b0);
        check_beat("tlp_b1", 64'h07060504030201FB, 24'o55555552, 1'b1, 1'b0);
        step(64'h1817161514131211, 8'hFF, 1'b0);
        check_beat("tlp_b2", 64'h1817161514131211, 24'o55555555, 1'b1, 1'b0);
        step(64'h27262524FD232221, 8'hFF, 1'b0);
        check_beat("tlp_b3", 64'h27262524FD232221, 24'o11114555, 1'b1, 1'b0);
        check_cnt("tlp_b3", 16'd2, 16'd0);

        // SDP then STP without END: abort, then idles.
        step(64'h000000000FB005C, 8'hFF, 1'b0);
        check_beat("abort", 64'h000000000FB005C, 24'o11111763, 1'b1, 1'b1);
        check_cnt("abort", 16'd2, 16'd0);

        // Open a DLLP at the last byte, then hold for three cycles.
        step(64'h5C00000000000000, 8'hFF, 1'b0);
        check_beat("dllp_open", 64'h5C00000000000000, 24'o31111111, 1'b1, 1'b0);
        step(64'hFDFDFDFDFDFDFDFD, 8'hFF, 1'b1);
        check_beat("hold1", 64'h5C00000000000000, 24'o31111111, 1'b0, 1'b0);
        step(64'hFBFBFBFBFBFBFBFB, 8'hFF, 1'b1);
        check_beat("hold2", 64'h5C00000000000000, 24'o31111111, 1'b0, 1'b0);
        step(64'h000000000000FDAA, 8'hFF, 1'b1);
        check_beat("hold3", 64'h5C00000000000000, 24'o31111111, 1'b0, 1'b0);
        check_cnt("hold3", 16'd2, 16'd0);
        step(64'h000000000000FDAA, 8'hFF, 1'b0);
        check_beat("release", 64'h000000000000FDAA, 24'o11111146, 1'b1, 1'b0);
        check_cnt("release", 16'd2, 16'd1);

        // All-invalid beat inside a TLP keeps the context.
        step(64'hFB11111111111111, 8'hFF, 1'b0);
        check_beat("tlp_open", 64'hFB11111111111111, 24'o21111111, 1'b1, 1'b0);
        step(64'hFDFDFDFDFDFDFDFD, 8'h00, 1'b0);
        check_beat("no_valid", 64'hFDFDFDFDFDFDFDFD, 24'o0, 1'b0, 1'b0);
        step(64'h0000000000000055, 8'h01, 1'b0);
        check_beat("body_55", 64'h0000000000000055, 24'o00000005, 1'b1, 1'b0);

        // Close the TLP and open a DLLP in one beat, then reset mid-DLLP.
        step(64'h0000000000005CFD, 8'h03, 1'b0);
        check_beat("close_open", 64'h0000000000005CFD, 24'o00000034, 1'b1, 1'b0);
        check_cnt("close_open", 16'd3, 16'd1);
        #2 rst = 1'b1;
        bus.valid = '0;
        #1;
        check_beat("async_rst", 64'h0, 24'o0, 1'b0, 1'b0);
        check_cnt("async_rst", 16'd0, 16'd0);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        step(64'h00000000000000FD, 8'h01, 1'b0);
        check_beat("end_after_rst", 64'h00000000000000FD, 24'o00000007, 1'b1, 1'b1);
        check_cnt("end_after_rst", 16'd0, 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
